// File: rtl/texmem_pkg.sv
// Purpose : shared geometry and FSM state encoding for the texture BRAM write path.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
// Contents: TEX_* geometry constants, tex_wr_state_e write-sequence states.
package texmem_pkg;

  localparam int TEX_ADDR_W   = 13;  // byte address, bank in [12:10]
  localparam int TEX_DATA_W   = 8;   // one write byte
  localparam int TEX_NBANK    = 8;   // 2^(TEX_ADDR_W-TEX_BANK_LSB)
  localparam int TEX_BANK_LSB = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE  = 3'd2,
    HOLD    = 3'd3,
    RECOVER = 3'd4
  } tex_wr_state_e;

endpackage

// File: rtl/texmem_write_arbiter_if.sv
// Purpose : bundle of the two requester ports and the BRAM write-side outputs.
// Latency : n/a (wiring only).
// Backpressure: reqN_ready from the arbiter gates reqN_valid transfers.
// Modports: master = requesters + BRAM/observer side, slave = the arbiter.
interface texmem_write_arbiter_if
  import texmem_pkg::*;
#(
  parameter int ADDR_W = TEX_ADDR_W,
  parameter int DATA_W = TEX_DATA_W,
  parameter int NBANK  = TEX_NBANK
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [NBANK-1:0]  wr_strobe;
  logic              busy;
  logic              wr_done;
  logic              wr_done_src;

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  wr_addr, wr_data, wr_strobe, busy, wr_done, wr_done_src
  );

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output wr_addr, wr_data, wr_strobe, busy, wr_done, wr_done_src
  );

endinterface

// File: rtl/texmem_write_arbiter_rr_arb2.sv
// Purpose : 2-way round-robin grant; a tie goes to the port not granted last.
// Latency : grant is combinational from req; last_grant updates on the accept edge.
// Backpressure: grant is only a proposal, the caller qualifies it and reports accept.
// Ports   : clk, reset_n (sync, active-low), req[1:0], accept -> gnt[1:0] one-hot/zero.
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  // Resets to 1 so that port 0 wins the first tie after reset.
  logic last_grant;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_grant ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
    end else if (accept) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/texmem_write_arbiter.sv
// Purpose : shares the texture BRAM write port between the loader (port 0) and a fabric writer (port 1).
// Latency : accept at T, strobe T+2..T+1+STROBE_CYCLES, wr_done in the last cycle, next accept one cycle later.
// Backpressure: reqN_ready only in IDLE (and out of reset); requests arriving while busy wait on valid.
// Ports   : clk, reset_n (sync, active-low), bus (slave modport: req0/req1 valid/addr/data/ready,
//           wr_addr, wr_data, wr_strobe, busy, wr_done, wr_done_src).
// Option  : TEXMEM_WR_AUTOINC_EN - port 0 ignores req0_addr and writes at an internal
//           auto-incrementing pointer (reset 0, wraps at 2^ADDR_W).
module texmem_write_arbiter
  import texmem_pkg::*;
#(
  parameter int ADDR_W         = TEX_ADDR_W,
  parameter int DATA_W         = TEX_DATA_W,
  parameter int NBANK          = TEX_NBANK,
  parameter int STROBE_CYCLES  = 2,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  texmem_write_arbiter_if.slave  bus
);

  localparam int BANK_W = ADDR_W - TEX_BANK_LSB;

  tex_wr_state_e     state_q, state_nxt;
  logic [2:0]        cnt_q, cnt_nxt;     // shared STROBE/RECOVER dwell counter
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [NBANK-1:0]  strobe_q, strobe_nxt;
  logic              done_q, done_nxt;
  logic              src_q;

  logic [1:0]        req;
  logic [1:0]        gnt;
  logic              idle;
  logic              accept;
  logic              acc_src;
  logic [ADDR_W-1:0] p0_addr;

  // Ready is gated by reset so no transfer is signalled while the FSM is being cleared.
  assign idle    = (state_q == IDLE) && reset_n;
  assign req     = {bus.req1_valid, bus.req0_valid};

  rr_arb2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .accept  (accept),
    .gnt     (gnt)
  );

  assign bus.req0_ready = idle & gnt[0];
  assign bus.req1_ready = idle & gnt[1];
  assign accept  = (bus.req0_ready & bus.req0_valid) | (bus.req1_ready & bus.req1_valid);
  assign acc_src = gnt[1];

`ifdef TEXMEM_WR_AUTOINC_EN
  logic [ADDR_W-1:0] p0_ptr;

  // Only port-0 accepts advance the pointer; natural wrap at 2^ADDR_W.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      p0_ptr <= '0;
    end else if (accept && !acc_src) begin
      p0_ptr <= p0_ptr + 1'b1;
    end
  end

  assign p0_addr = p0_ptr;
`else
  assign p0_addr = bus.req0_addr;
`endif

  // Next-state, counter and registered-output precompute.
  always_comb begin
    state_nxt  = state_q;
    cnt_nxt    = cnt_q;
    strobe_nxt = '0;
    done_nxt   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        state_nxt = STROBE;
        cnt_nxt   = 3'(STROBE_CYCLES - 1);
      end
      STROBE: begin
        if (cnt_q == 3'd0) begin
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      HOLD: begin
        if (RECOVER_CYCLES == 0) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = RECOVER;
          cnt_nxt   = 3'(RECOVER_CYCLES - 1);
        end
      end
      RECOVER: begin
        if (cnt_q == 3'd0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt_q - 3'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    // wr_addr is already stable when STROBE is entered (latched at accept).
    if (state_nxt == STROBE) begin
      strobe_nxt[wr_addr_q[ADDR_W-1 -: BANK_W]] = 1'b1;
    end

    // Final cycle of the sequence: last RECOVER cycle, or HOLD when there is no recovery.
    done_nxt = ((state_nxt == RECOVER) && (cnt_nxt == 3'd0)) ||
               ((state_nxt == HOLD) && (RECOVER_CYCLES == 0));
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= 3'd0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      strobe_q  <= '0;
      done_q    <= 1'b0;
      src_q     <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      strobe_q <= strobe_nxt;
      done_q   <= done_nxt;
      if (accept) begin
        wr_addr_q <= acc_src ? bus.req1_addr : p0_addr;
        wr_data_q <= acc_src ? bus.req1_data : bus.req0_data;
        src_q     <= acc_src;
      end
    end
  end

  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.wr_strobe   = strobe_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.wr_done     = done_q;
  assign bus.wr_done_src = src_q;

endmodule

// File: tb/tb_texmem_write_arbiter.sv
// Purpose : directed self-checking bench for texmem_write_arbiter (default timing and 1/0 timing instances).
// Latency : n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_texmem_write_arbiter;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  texmem_write_arbiter_if ba ();
  texmem_write_arbiter_if bb ();

  texmem_write_arbiter dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (ba)
  );

  texmem_write_arbiter #(
    .STROBE_CYCLES  (1),
    .RECOVER_CYCLES (0)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bb)
  );

  int checks = 0;
  int errors = 0;

  // Port-0 effective address model (internal pointer when auto-increment is built in).
  logic [12:0] ptr_a = '0;
  logic [12:0] ptr_b = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] eff0(input logic [12:0] req_addr, input logic [12:0] ptr);
`ifdef TEXMEM_WR_AUTOINC_EN
    return ptr;
`else
    return req_addr;
`endif
  endfunction

  function automatic logic [7:0] strobe_of(input logic [12:0] a);
    logic [7:0] s;
    s = 8'h00;
    s[a[12:10]] = 1'b1;
    return s;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    ptr_a = '0;
    ptr_b = '0;
  endtask

  task automatic wait_idle(input int which);
    logic b;
    b = 1'b1;
    for (int n = 0; n < 20; n++) begin
      #1;
      b = (which == 0) ? ba.busy : bb.busy;
      if (!b) break;
      @(negedge clk);
    end
    check("idle_timeout", b, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [12:0] ea;
    logic        found;
    logic        done_seen;
    int          cyc;
    int          prev;

    ba.req0_valid = 0; ba.req0_addr = '0; ba.req0_data = '0;
    ba.req1_valid = 0; ba.req1_addr = '0; ba.req1_data = '0;
    bb.req0_valid = 0; bb.req0_addr = '0; bb.req0_data = '0;
    bb.req1_valid = 0; bb.req1_addr = '0; bb.req1_data = '0;

    // ---- reset state
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy",   ba.busy,        1'b0);
    check("rst_strobe", ba.wr_strobe,   8'h00);
    check("rst_addr",   ba.wr_addr,     13'h0000);
    check("rst_data",   ba.wr_data,     8'h00);
    check("rst_done",   ba.wr_done,     1'b0);
    check("rst_src",    ba.wr_done_src, 1'b0);
    check("rst_rdy0",   ba.req0_ready,  1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---- single port-0 write, default timing
    @(negedge clk);
    ba.req0_valid = 1; ba.req0_addr = 13'h0005; ba.req0_data = 8'hA5;
    #1;
    check("t1_rdy0", ba.req0_ready, 1'b1);
    check("t1_rdy1", ba.req1_ready, 1'b0);
    ea = eff0(13'h0005, ptr_a);
    ptr_a = ptr_a + 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ba.req0_valid = 0;
      #1;
      check($sformatf("t1_strobe_T+%0d", k), ba.wr_strobe,
            (k == 2 || k == 3) ? strobe_of(ea) : 8'h00);
      check($sformatf("t1_addr_T+%0d", k), ba.wr_addr, ea);
      check($sformatf("t1_data_T+%0d", k), ba.wr_data, 8'hA5);
      check($sformatf("t1_done_T+%0d", k), ba.wr_done, (k == 6));
      check($sformatf("t1_busy_T+%0d", k), ba.busy, (k <= 6));
      if (k == 6) check("t1_src", ba.wr_done_src, 1'b0);
    end

    // ---- both valid continuously: round-robin, 7-cycle spacing
    do_reset();
    ba.req0_valid = 1; ba.req0_addr = 13'h0400; ba.req0_data = 8'h11;
    ba.req1_valid = 1; ba.req1_addr = 13'h1C00; ba.req1_data = 8'h22;
    cyc  = 0;
    prev = -1;
    for (int g = 0; g < 4; g++) begin
      found = 1'b0;
      for (int w = 0; w < 12; w++) begin
        #1;
        if (ba.req0_ready || ba.req1_ready) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
        cyc++;
      end
      check("t2_grant_seen", found, 1'b1);
      if (found) begin
        check($sformatf("t2_grant%0d", g), ba.req1_ready, (g % 2));
        check("t2_single_ready", ba.req0_ready & ba.req1_ready, 1'b0);
        if (prev >= 0) check("t2_gap", cyc - prev, 7);
        prev = cyc;
        if (g % 2 == 0) begin
          ea = eff0(13'h0400, ptr_a);
          ptr_a = ptr_a + 1'b1;
        end else begin
          ea = 13'h1C00;
        end
        @(negedge clk);
        @(negedge clk);
        cyc += 2;
        #1;
        check($sformatf("t2_strobe%0d", g), ba.wr_strobe, strobe_of(ea));
      end
    end
`ifndef TEXMEM_WR_AUTOINC_EN
    check("t2_last_strobe_port1", ba.wr_strobe, 8'h80);
`endif
    @(negedge clk);
    ba.req0_valid = 0; ba.req1_valid = 0;
    wait_idle(0);

    // ---- req1 arrives while busy, waits until the sequence ends
    @(negedge clk);
    ba.req0_valid = 1; ba.req0_addr = 13'h0010; ba.req0_data = 8'h33;
    #1;
    check("t3_rdy0", ba.req0_ready, 1'b1);
    ptr_a = ptr_a + 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      ba.req0_valid = 0;
      ba.req1_valid = 1; ba.req1_addr = 13'h0C01; ba.req1_data = 8'h44;
      #1;
      check($sformatf("t3_rdy1_T+%0d", k), ba.req1_ready, (k == 7));
    end
    @(negedge clk);
    ba.req1_valid = 0;
    #1;
    check("t3_addr", ba.wr_addr, 13'h0C01);
    check("t3_data", ba.wr_data, 8'h44);
    wait_idle(0);

    // ---- reset mid-strobe
    @(negedge clk);
    ba.req0_valid = 1; ba.req0_addr = 13'h0805; ba.req0_data = 8'h55;
    #1;
    check("t4_rdy0", ba.req0_ready, 1'b1);
    ea = eff0(13'h0805, ptr_a);
    @(negedge clk);
    ba.req0_valid = 0;
    @(negedge clk);
    #1;
    check("t4_strobe_pre", ba.wr_strobe, strobe_of(ea));
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    check("t4_strobe_rst", ba.wr_strobe, 8'h00);
    check("t4_busy_rst",   ba.busy,      1'b0);
    done_seen = ba.wr_done;
    reset_n = 1'b1;
    ptr_a = '0;
    ptr_b = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      #1;
      done_seen = done_seen | ba.wr_done;
    end
    check("t4_no_done", done_seen, 1'b0);
    @(negedge clk);
    ba.req0_valid = 1; ba.req0_addr = 13'h0001; ba.req0_data = 8'h01;
    ba.req1_valid = 1; ba.req1_addr = 13'h0002; ba.req1_data = 8'h02;
    #1;
    check("t4_tie_rdy0", ba.req0_ready, 1'b1);
    check("t4_tie_rdy1", ba.req1_ready, 1'b0);
    ptr_a = ptr_a + 1'b1;
    @(negedge clk);
    ba.req0_valid = 0; ba.req1_valid = 0;
    #1;
    check("t4_tie_src_addr", ba.wr_addr, eff0(13'h0001, 13'h0000));
    wait_idle(0);

    // ---- STROBE_CYCLES=1, RECOVER_CYCLES=0 instance
    @(negedge clk);
    bb.req0_valid = 1; bb.req0_addr = 13'h1005; bb.req0_data = 8'h66;
    #1;
    check("t5_rdy0", bb.req0_ready, 1'b1);
    ea = eff0(13'h1005, ptr_b);
    ptr_b = ptr_b + 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bb.req0_addr = 13'h1006; bb.req0_data = 8'h67;
      #1;
      check($sformatf("t5_strobe_T+%0d", k), bb.wr_strobe, (k == 2) ? strobe_of(ea) : 8'h00);
      check($sformatf("t5_done_T+%0d", k),   bb.wr_done,   (k == 3));
      check($sformatf("t5_rdy0_T+%0d", k),   bb.req0_ready, (k == 4));
    end
    @(negedge clk);
    bb.req0_valid = 0;
    #1;
    check("t5_second_data", bb.wr_data, 8'h67);
    wait_idle(1);

`ifdef TEXMEM_WR_AUTOINC_EN
    // ---- auto-increment: req0_addr ignored, pointer 0,1,2 after reset
    do_reset();
    for (int n = 0; n < 3; n++) begin
      ba.req0_valid = 1; ba.req0_addr = 13'h1FFF; ba.req0_data = 8'(n);
      #1;
      check("t6_rdy0", ba.req0_ready, 1'b1);
      @(negedge clk);
      ba.req0_valid = 0;
      #1;
      check($sformatf("t6_addr%0d", n), ba.wr_addr, 13'(n));
      wait_idle(0);
      @(negedge clk);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
